// File: rtl/pl_pkg.sv
// Shared types and helpers for the pseudo-linear learner: FSM states, forward
// decision and popcount-width derivation.
package pl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DECIDE,
        UPDATE,
        DONE
    } pl_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Operands arrive zero-extended, so the compare matches a CNT_W-bit compare.
    function automatic logic fwd(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sh);
        return ((b >> sh) >= a) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/pl_popcnt_chunk.sv
// Combinational population count of one W-bit chunk.
module pl_popcnt_chunk
    import pl_pkg::*;
#(
    parameter  int W     = 16,
    localparam int OUT_W = cnt_w(W)
) (
    input  logic [W-1:0]     bits,
    output logic [OUT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + OUT_W'(bits[i]);
    end

endmodule

// File: rtl/pseudo_linear_learner.sv
// Single-class pseudo-linear classifier with on-error reverse-derivative update,
// processing CHUNK feature bits per cycle.
module pseudo_linear_learner
    import pl_pkg::*;
#(
    parameter  int N_FEAT = 784,
    parameter  int CHUNK  = 16,
    parameter  int THR_W  = 4,
    localparam int CNT_W  = cnt_w(N_FEAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    input  logic              in_label,
    input  logic              in_train,
    input  logic [THR_W-1:0]  thr,
    input  logic              p_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_result,
    output logic              out_error,
    output logic [CNT_W-1:0]  out_nflip,
    output logic [N_FEAT-1:0] pm
);

    localparam int NCHUNK = N_FEAT / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = cnt_w(CHUNK);

    typedef struct packed {
        logic [N_FEAT-1:0] x;
        logic              label;
        logic              train;
        logic [THR_W-1:0]  thr;
    } sample_t;

    pl_state_e         state, state_nx;
    sample_t           smp;
    logic [N_FEAT-1:0] p;
    logic [CNT_W-1:0]  cnt_and, cnt_p, nflip;
    logic [IDX_W-1:0]  idx;
    logic              res, err_q;

    logic [31:0]       base;
    logic [CHUNK-1:0]  p_ch, x_ch, px_ch, flip;
    logic [PC_W-1:0]   pc_and, pc_p, pc_flip;
    logic [CNT_W-1:0]  a_m, b_m;
    logic              accept, last_chunk, dec_res, dec_err;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid & in_ready & ~p_clr;
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
    assign base       = 32'(idx) * CHUNK;
    assign p_ch       = p[base +: CHUNK];
    assign x_ch       = smp.x[base +: CHUNK];
    assign px_ch      = p_ch & x_ch;
    assign dec_res    = fwd(32'(cnt_and), 32'(cnt_p), 32'(smp.thr));
    assign dec_err    = dec_res ^ smp.label;

    pl_popcnt_chunk #(.W(CHUNK)) u_pc_and  (.bits(px_ch), .cnt(pc_and));
    pl_popcnt_chunk #(.W(CHUNK)) u_pc_p    (.bits(p_ch),  .cnt(pc_p));
    pl_popcnt_chunk #(.W(CHUNK)) u_pc_flip (.bits(flip),  .cnt(pc_flip));

    // A bit flips when toggling it alone would change the decision; counts are
    // the pre-update totals, and each chunk only sees its own original p bits.
    always_comb begin
        flip = '0;
        a_m  = '0;
        b_m  = '0;
        for (int m = 0; m < CHUNK; m++) begin
            a_m = x_ch[m] ? (p_ch[m] ? cnt_and - CNT_W'(1) : cnt_and + CNT_W'(1)) : cnt_and;
            b_m = p_ch[m] ? cnt_p - CNT_W'(1) : cnt_p + CNT_W'(1);
            flip[m] = res ^ fwd(32'(a_m), 32'(b_m), 32'(smp.thr));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (p_clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = COUNT;
                COUNT:   if (last_chunk) state_nx = DECIDE;
                DECIDE:  state_nx = (smp.train && dec_err) ? UPDATE : DONE;
                UPDATE:  if (last_chunk) state_nx = DONE;
                DONE:    if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp     <= '0;
            p       <= '0;
            cnt_and <= '0;
            cnt_p   <= '0;
            nflip   <= '0;
            idx     <= '0;
            res     <= 1'b0;
            err_q   <= 1'b0;
        end else if (p_clr) begin
            p       <= '0;
            cnt_and <= '0;
            cnt_p   <= '0;
            nflip   <= '0;
            idx     <= '0;
            res     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    smp     <= '{x: in_feat, label: in_label, train: in_train, thr: thr};
                    cnt_and <= '0;
                    cnt_p   <= '0;
                    nflip   <= '0;
                    idx     <= '0;
                    res     <= 1'b0;
                    err_q   <= 1'b0;
                end
                COUNT: begin
                    cnt_and <= cnt_and + CNT_W'(pc_and);
                    cnt_p   <= cnt_p + CNT_W'(pc_p);
                    idx     <= last_chunk ? '0 : idx + IDX_W'(1);
                end
                DECIDE: begin
                    res   <= dec_res;
                    err_q <= smp.train & dec_err;
                    idx   <= '0;
                end
                UPDATE: begin
                    p[base +: CHUNK] <= p_ch ^ flip;
                    nflip            <= nflip + CNT_W'(pc_flip);
                    idx              <= last_chunk ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = (state == DONE);
    assign out_result = res;
    assign out_error  = err_q;
    assign out_nflip  = nflip;
    assign pm         = p;

endmodule

// File: tb/tb_pseudo_linear_learner.sv
// Randomized self-checking bench for pseudo_linear_learner (N_FEAT=16, CHUNK=4).
module tb_pseudo_linear_learner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_feat = '0;
    logic        in_label = 1'b0;
    logic        in_train = 1'b0;
    logic [3:0]  thr = '0;
    logic        p_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_result;
    logic        out_error;
    logic [4:0]  out_nflip;
    logic [15:0] pm;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] p_model = '0;

    pseudo_linear_learner #(.N_FEAT(16), .CHUNK(4), .THR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .in_label(in_label), .in_train(in_train), .thr(thr),
        .p_clr(p_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_error(out_error), .out_nflip(out_nflip), .pm(pm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_fwd(input int a, input int b, input int sh);
        return (b >> sh) < a;
    endfunction

    // Model: decide from whole-vector popcounts; on a training error, flip each
    // bit whose solo toggle changes the decision of the toggled vector.
    task automatic send(input logic [15:0] x, input logic lbl, input logic trn,
                        input logic [3:0] th, input int hold);
        logic        er, ee, sr, se;
        logic [15:0] flip, pt, pexp, spm;
        logic [4:0]  sn;
        int          lat, elat;
        er   = ref_fwd($countones(p_model & x), $countones(p_model), int'(th));
        ee   = trn & (er ^ lbl);
        flip = '0;
        if (ee) begin
            for (int m = 0; m < 16; m++) begin
                pt = p_model ^ (16'h1 << m);
                if (ref_fwd($countones(pt & x), $countones(pt), int'(th)) != er) flip[m] = 1'b1;
            end
        end
        pexp = p_model ^ flip;
        elat = ee ? 10 : 6;

        @(negedge clk);
        in_feat = x; in_label = lbl; in_train = trn; thr = th; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("result", out_result, er);
        check("error", out_error, ee);
        check("nflip", out_nflip, $countones(flip));
        check("pm", pm, pexp);
        p_model = pexp;

        sr = out_result; se = out_error; sn = out_nflip; spm = pm;
        repeat (hold) begin
            in_valid = 1'b1;
            in_feat  = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", out_result, sr);
            check("hold_error", out_error, se);
            check("hold_nflip", out_nflip, sn);
            check("hold_pm", pm, spm);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", out_result, 0);
        check("rst_error", out_error, 0);
        check("rst_nflip", out_nflip, 0);
        check("rst_pm", pm, 0);
        @(negedge clk); rst_n = 1'b1;

        send(16'hFFFF, 1'b0, 1'b0, 4'd0, 0);
        send(16'h00F0, 1'b1, 1'b1, 4'd1, 0);
        check("pm_after_train", pm, 16'h00F0);
        send(16'h00F0, 1'b0, 1'b0, 4'd1, 0);
        check("infer_result", out_result, 1);
        send(16'h00F0, 1'b1, 1'b1, 4'd1, 5);
        check("pm_no_update", pm, 16'h00F0);

        for (int i = 0; i < 40; i++)
            send(16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));

        // p_clr in IDLE, sharing the cycle with an offered sample
        @(negedge clk);
        in_valid = 1'b1; in_feat = 16'h0F0F; in_label = 1'b1; in_train = 1'b1; thr = 4'd1;
        p_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; p_clr = 1'b0;
        p_model = '0;
        check("clr_prio_ready", in_ready, 1);
        check("clr_prio_pm", pm, 0);
        watch_quiet("clr_prio_no_valid", 12);

        // p_clr while UPDATE is half done
        @(negedge clk);
        in_valid = 1'b1; in_feat = 16'h0F0F; in_label = 1'b1; in_train = 1'b1; thr = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_update_pm", pm, 16'h000F);
        check("mid_update_valid", out_valid, 0);
        @(negedge clk); p_clr = 1'b1;
        @(posedge clk); #1; p_clr = 1'b0;
        check("clr_update_pm", pm, 0);
        check("clr_update_ready", in_ready, 1);
        watch_quiet("clr_update_no_valid", 12);

        // async reset while counting
        send(16'h00F0, 1'b1, 1'b1, 4'd1, 0);
        @(negedge clk);
        in_valid = 1'b1; in_feat = 16'hFFFF; in_label = 1'b0; in_train = 1'b1; thr = 4'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pm", pm, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_valid", out_valid, 0);
        p_model = '0;
        @(negedge clk); rst_n = 1'b1;
        watch_quiet("rst_mid_no_valid", 12);

        send(16'h00F0, 1'b1, 1'b1, 4'd1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
